// File: rtl/clock_set_ctrl.sv
// Sequencing controller for the 12-hour clock core: 1 Hz prescaler,
// RUN / SET_HOUR / SET_MIN mode FSM driven by two push-buttons, and
// single-cycle increment / clear commands for the time counters.
module clock_set_ctrl #(
   parameter int unsigned TICK_DIV    = 10000000,
   parameter int unsigned HOLD_CYC    = 5000000,
   parameter int unsigned REPEAT_CYC  = 2000000,
   parameter int unsigned TIMEOUT_CYC = 100000000,
   parameter int unsigned BLINK_CYC   = 5000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic       btn_mode,
   input  logic       btn_inc,
   output logic       tick_en,
   output logic       inc_hour,
   output logic       inc_min,
   output logic       clr_sec,
   output logic [1:0] mode,
   output logic       blink
);

   localparam int unsigned HOLD_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
   localparam int unsigned PW = $clog2(TICK_DIV);
   localparam int unsigned HW = $clog2(HOLD_MAX);
   localparam int unsigned IW = $clog2(TIMEOUT_CYC);
   localparam int unsigned BW = $clog2(BLINK_CYC);

   localparam logic [PW-1:0] PRESC_LAST  = PW'(TICK_DIV - 1);
   localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_CYC - 1);
   localparam logic [HW-1:0] REPEAT_LAST = HW'(REPEAT_CYC - 1);
   localparam logic [IW-1:0] IDLE_LAST   = IW'(TIMEOUT_CYC - 1);
   localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_CYC - 1);

   typedef enum logic [1:0] {
      RUN      = 2'b00,
      SET_HOUR = 2'b01,
      SET_MIN  = 2'b10
   } state_t;

   state_t state, state_nxt;

   logic          mode_s1, mode_s2, mode_s3;
   logic          inc_s1, inc_s2, inc_s3;
   logic [PW-1:0] presc;
   logic [HW-1:0] hold_cnt;
   logic          hold_arm;
   logic          hold_rep;
   logic [IW-1:0] idle_cnt;
   logic [BW-1:0] blink_cnt;

   logic          mode_edge, inc_edge, timeout, in_set, changing;
   logic          hold_run, rep_fire, inc_pulse;
   logic [HW-1:0] hold_lim;
   logic          tick_nxt, inc_hour_nxt, inc_min_nxt, clr_nxt;

   assign mode = state;

   // Mode FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
      end else if (ena) begin
         state <= state_nxt;
      end
   end

   // Next state, auto-repeat decision and next values of the command pulses.
   always_comb begin
      mode_edge    = ena & mode_s2 & ~mode_s3;
      inc_edge     = ena & inc_s2 & ~inc_s3;
      in_set       = (state != RUN);
      timeout      = ena & in_set & (idle_cnt == IDLE_LAST);
      state_nxt    = state;
      if (mode_edge) begin
         case (state)
            RUN:      state_nxt = SET_HOUR;
            SET_HOUR: state_nxt = SET_MIN;
            default:  state_nxt = RUN;
         endcase
      end else if (timeout) begin
         state_nxt = RUN;
      end
      changing     = (state_nxt != state);
      // Auto-repeat only runs after an accepted edge pulse in this same state.
      hold_run     = ena & in_set & ~changing & hold_arm & inc_s2 & ~inc_edge;
      hold_lim     = hold_rep ? REPEAT_LAST : HOLD_LAST;
      rep_fire     = hold_run & (hold_cnt == hold_lim);
      inc_pulse    = ena & in_set & ~changing & (inc_edge | rep_fire);
      tick_nxt     = ena & (state == RUN) & (state_nxt == RUN) & (presc == PRESC_LAST);
      inc_hour_nxt = inc_pulse & (state == SET_HOUR);
      inc_min_nxt  = inc_pulse & (state == SET_MIN);
      clr_nxt      = ena & in_set & (state_nxt == RUN);
   end

   // Button synchronizers plus previous-value flop for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_s1 <= 1'b0;
         mode_s2 <= 1'b0;
         mode_s3 <= 1'b0;
         inc_s1  <= 1'b0;
         inc_s2  <= 1'b0;
         inc_s3  <= 1'b0;
      end else if (ena) begin
         mode_s1 <= btn_mode;
         mode_s2 <= mode_s1;
         mode_s3 <= mode_s2;
         inc_s1  <= btn_inc;
         inc_s2  <= inc_s1;
         inc_s3  <= inc_s2;
      end
   end

   // Registered single-cycle command outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_en  <= 1'b0;
         inc_hour <= 1'b0;
         inc_min  <= 1'b0;
         clr_sec  <= 1'b0;
      end else begin
         tick_en  <= tick_nxt;
         inc_hour <= inc_hour_nxt;
         inc_min  <= inc_min_nxt;
         clr_sec  <= clr_nxt;
      end
   end

   // Prescaler, hold/repeat, idle-timeout and blink counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc     <= '0;
         hold_cnt  <= '0;
         hold_arm  <= 1'b0;
         hold_rep  <= 1'b0;
         idle_cnt  <= '0;
         blink_cnt <= '0;
         blink     <= 1'b0;
      end else if (ena) begin
         if ((state == RUN) && (state_nxt == RUN)) begin
            presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
         end else begin
            presc <= '0;
         end

         if (inc_pulse && inc_edge) begin
            hold_arm <= 1'b1;
            hold_rep <= 1'b0;
            hold_cnt <= '0;
         end else if (rep_fire) begin
            hold_rep <= 1'b1;
            hold_cnt <= '0;
         end else if (hold_run) begin
            hold_cnt <= hold_cnt + 1'b1;
         end else begin
            hold_arm <= 1'b0;
            hold_rep <= 1'b0;
            hold_cnt <= '0;
         end

         if (!in_set || changing || mode_edge || inc_edge || rep_fire) begin
            idle_cnt <= '0;
         end else begin
            idle_cnt <= idle_cnt + 1'b1;
         end

         if (state_nxt == RUN) begin
            blink     <= 1'b0;
            blink_cnt <= '0;
         end else if (changing) begin
            blink     <= 1'b1;
            blink_cnt <= '0;
         end else if (blink_cnt == BLINK_LAST) begin
            blink     <= ~blink;
            blink_cnt <= '0;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end

endmodule
